// File: rtl/trng_modp_gen_pkg.sv
// Shared definitions for the modular-range TRNG: FSM state encoding and default modulus.
package trng_modp_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_WAIT
    } state_e;

    localparam logic [255:0] P_DEFAULT =
        256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

endpackage

// File: rtl/trng_health_rct.sv
// Repetition-count health test: trips a sticky fault after RCT_LIMIT identical raw bits in a row.
module trng_health_rct #(
    parameter int unsigned RCT_LIMIT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_i,
    input  logic valid_i,
    output logic fault_o
);
    localparam int unsigned CW = $clog2(RCT_LIMIT + 1);

    logic [CW-1:0] run_q, run_d;
    logic          last_q, last_d;
    logic          fault_q, fault_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        run_d   = run_q;
        last_d  = last_q;
        fault_d = fault_q;
        if (valid_i && !fault_q) begin
            last_d = bit_i;
            // run_q == 0 means no bit seen yet since reset
            if (run_q != '0 && bit_i == last_q) run_d = run_q + 1'b1;
            else                                run_d = CW'(1);
            if (run_d == CW'(RCT_LIMIT)) fault_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= '0;
            last_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            last_q  <= last_d;
            fault_q <= fault_d;
        end
    end

    assign fault_o = fault_q;

endmodule

// File: rtl/trng_modp_gen.sv
// TRNG producing uniform values in [0, P-1]: debias, W-bit assembly, rejection sampling, word-wise readout.
module trng_modp_gen
    import trng_modp_gen_pkg::*;
#(
    parameter int unsigned    W         = 256,
    parameter int unsigned    WORD      = 32,
    parameter logic [W-1:0]   P         = P_DEFAULT[W-1:0],
    parameter bit             DEBIAS    = 1'b1,
    parameter int unsigned    RCT_LIMIT = 32,
    localparam int unsigned   NW        = W / WORD,
    localparam int unsigned   AW        = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            ent_bit_i,
    input  logic            ent_valid_i,
    input  logic            rd_en_i,
    input  logic [AW-1:0]   rd_addr_i,
    output logic [WORD-1:0] rd_data_o,
    output logic            rdy_o,
    output logic            fault_o,
    output logic [15:0]     rej_cnt_o
);
    localparam int unsigned CW = $clog2(W + 1);

    state_e          state_q, state_d;
    logic [W-1:0]    sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pair_q, pair_d;
    logic            pbit_q, pbit_d;
    logic [W-1:0]    hold_q, hold_d;
    logic            rdy_q, rdy_d;
    logic [WORD-1:0] rd_data_q, rd_data_d;
    logic [15:0]     rej_q, rej_d;

    logic fault;
    logic db_valid, db_bit;
    logic rd_ok, consume, buf_free;

    trng_health_rct #(.RCT_LIMIT(RCT_LIMIT)) u_rct (
        .clk     (clk),
        .rst     (rst),
        .bit_i   (ent_bit_i),
        .valid_i (ent_valid_i),
        .fault_o (fault)
    );

    // Von Neumann pairing only while collecting; a half pair survives valid gaps.
    always_comb begin
        pair_d   = pair_q;
        pbit_d   = pbit_q;
        db_valid = 1'b0;
        db_bit   = 1'b0;
        if (state_q != ST_COLLECT) begin
            pair_d = 1'b0;
        end else if (ent_valid_i) begin
            if (!DEBIAS) begin
                db_valid = 1'b1;
                db_bit   = ent_bit_i;
            end else if (!pair_q) begin
                pair_d = 1'b1;
                pbit_d = ent_bit_i;
            end else begin
                pair_d = 1'b0;
                if (pbit_q != ent_bit_i) begin
                    db_valid = 1'b1;
                    db_bit   = pbit_q;
                end
            end
        end
    end

    assign rd_ok    = rd_en_i && rdy_q && !fault;
    assign consume  = rd_ok && (rd_addr_i == AW'(NW - 1));
    assign buf_free = !rdy_q || consume;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        rdy_d     = rdy_q;
        rej_d     = rej_q;
        rd_data_d = rd_data_q;

        if (rd_ok) rd_data_d = hold_q[32'(rd_addr_i) * WORD +: WORD];
        if (consume) rdy_d = 1'b0;

        if (fault || !en_i) begin
            state_d = ST_IDLE;
            sr_d    = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_COLLECT;
                ST_COLLECT: begin
                    if (db_valid) begin
                        sr_d  = {sr_q[W-2:0], db_bit};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(W - 1)) state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    cnt_d   = '0;
                    state_d = ST_COLLECT;
                    if (sr_q >= P) begin
                        if (rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
                    end else if (buf_free) begin
                        hold_d = sr_q;
                        rdy_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (buf_free) begin
                        hold_d  = sr_q;
                        rdy_d   = 1'b1;
                        state_d = ST_COLLECT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (fault) rdy_d = 1'b0;
    end

    // NOTE: the hold buffer is a plain register, so it is reset along with everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            pair_q    <= 1'b0;
            pbit_q    <= 1'b0;
            hold_q    <= '0;
            rdy_q     <= 1'b0;
            rd_data_q <= '0;
            rej_q     <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            pair_q    <= pair_d;
            pbit_q    <= pbit_d;
            hold_q    <= hold_d;
            rdy_q     <= rdy_d;
            rd_data_q <= rd_data_d;
            rej_q     <= rej_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rdy_o     = rdy_q && !fault;
    assign fault_o   = fault;
    assign rej_cnt_o = rej_q;

endmodule
